mem_latency_responder: RTL
==========================

// Module: mem_latency_responder
// PURPOSE
//  Memory-side responder for the riscv_top external memory port (mem_req_* / mem_resp_*).
//  Accepts and queues requests; services them in order after a programmable latency.
//  Reads return a BEATS-beat line burst; writes absorb one masked data beat.
//  Instantiated in the test harness opposite riscv_top; loaded via $readmemh on `ram`.
// PARAMETERS
//  ADDR_BITS   28   mem_req_addr width, in DATA_BITS-wide word units
//  DATA_BITS   128  data beat width
//  TAG_BITS    5    request/response tag width
//  RAM_LOG2    14   backing store depth = 2**RAM_LOG2 words
//  LATENCY     8    cycles from request acceptance to first beat / data_ready (>=2)
//  QDEPTH      4    request queue entries (power of 2)
//  BEATS       4    read burst length (power of 2)
// PORTS
//  clk                 in   1            clock, rising edge
//  reset               in   1            synchronous, active-high
//  mem_req_valid       in   1            request present
//  mem_req_ready       out  1            queue can accept
//  mem_req_rw          in   1            1=write, 0=read
//  mem_req_addr        in   ADDR_BITS    word address
//  mem_req_tag         in   TAG_BITS     echoed on read beats
//  mem_req_data_valid  in   1            write beat present
//  mem_req_data_ready  out  1            write beat accepted this cycle
//  mem_req_data_bits   in   DATA_BITS    write data
//  mem_req_data_mask   in   DATA_BITS/8  byte enables, 1=write byte
//  mem_resp_valid      out  1            read beat valid (no backpressure)
//  mem_resp_tag        out  TAG_BITS     tag of head read
//  mem_resp_data       out  DATA_BITS    read beat
// BEHAVIOUR
//  - Reset: queue empty, FSM IDLE; mem_req_ready=0 during reset cycle, 1 the cycle after;
//    mem_req_data_ready=0, mem_resp_valid=0, tag/data=0. ram contents NOT cleared.
//  - Request enqueued {rw,addr,tag} on rising edge with valid&&ready.
//  - mem_req_ready = (count<QDEPTH), from registered count only: a full queue keeps ready
//    low even in a cycle where the head dequeues.
//  - FSM: IDLE -> WAIT when queue non-empty; WAIT holds a down-counter;
//    WAIT -> RBURST (rw=0) or WDATA (rw=1) on expiry.
//    RBURST: BEATS consecutive cycles, mem_resp_valid=1, beat i reads
//    ram[{addr[ADDR_BITS-1:log2 BEATS], i}] (low addr bits ignored), tag = head tag;
//    after last beat pop head -> IDLE.
//    WDATA: mem_req_data_ready=1 until data_valid; on that edge write ram[addr] byte-wise
//    per mask, pop head -> IDLE. No response for writes.
//  - Latency: head accepted at edge T into empty idle block -> first beat / data_ready
//    high in cycle after edge T+LATENCY-1 (LATENCY cycles). Later entries start WAIT the
//    cycle after the previous entry completes; no overlap.
//  - Address bits above RAM_LOG2 ignored (wrap modulo depth).
//  - mem_req_data_valid outside WDATA ignored, no effect on ram.
//  - Enqueue and dequeue same edge: count unchanged, both take effect.
//  - Reset mid-burst/mid-wait: outstanding requests dropped, burst truncated, outputs to
//    reset values next cycle; a write not yet in WDATA never reaches ram.
// CONFIGURATION
//  MEM_RANDOM_LATENCY_EN defined: WAIT length = LATENCY + lfsr[2:0] (0..7 extra);
//    16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, steps on each WAIT entry.
//    Order preserved.
//  Undefined: WAIT length exactly LATENCY; no LFSR logic present.
// TESTING
//  1 reset held 3 cycles, release -> ready=1 next cycle, resp_valid=0, data_ready=0.
//  2 ram[0x40..0x43]=A0..A3; read addr=0x41 tag=5 at edge T -> beats A0,A1,A2,A3 with
//    tag=5 in 4 consecutive cycles starting LATENCY cycles after T.
//  3 ram[0x10]=0; write addr=0x10 data=all-FF mask=16'h00F0 -> data_ready after LATENCY,
//    then read 0x10 -> beat0 bytes 4..7 = FF, other bytes 00.
//  4 5 back-to-back reads with resp unconsumed -> ready low after 4th, 5th accepted after
//    1st burst ends; all 5 bursts in order with correct tags.
//  5 reset asserted during beat 2 of a burst with 2 queued -> resp_valid=0 next cycle; no
//    further beats; new read after release returns correct data.
//  6 MEM_RANDOM_LATENCY_EN: 20 reads -> each first beat LATENCY..LATENCY+7 cycles after
//    head becomes active; order/tags preserved; same sequence on every run.

Source files
------------

// File: rtl/mem_latency_responder_if.sv
// Request/response bundle between riscv_top's external memory port and the memory responder.
interface mem_latency_responder_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5
);
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_rw;
  logic [ADDR_BITS-1:0]   mem_req_addr;
  logic [TAG_BITS-1:0]    mem_req_tag;
  logic                   mem_req_data_valid;
  logic                   mem_req_data_ready;
  logic [DATA_BITS-1:0]   mem_req_data_bits;
  logic [DATA_BITS/8-1:0] mem_req_data_mask;
  logic                   mem_resp_valid;
  logic [TAG_BITS-1:0]    mem_resp_tag;
  logic [DATA_BITS-1:0]   mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_tag, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_tag, mem_resp_data
  );
endinterface

// File: rtl/mem_latency_responder.sv
// In-order memory responder with programmable latency: BEATS-beat read bursts, masked single-beat writes.
// Optional MEM_RANDOM_LATENCY_EN adds 0..7 LFSR-driven extra wait cycles per request.
module mem_latency_responder #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5,
  parameter int RAM_LOG2  = 14,
  parameter int LATENCY   = 8,
  parameter int QDEPTH    = 4,
  parameter int BEATS     = 4
) (
  input logic clk,
  input logic reset,
  mem_latency_responder_if.slave mem
);
  localparam int QW = $clog2(QDEPTH);
  localparam int BW = $clog2(BEATS);
  localparam int CW = $clog2(LATENCY + 8) + 1;
  localparam int MW = DATA_BITS / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RBURST, S_WDATA} state_t;

  logic [DATA_BITS-1:0] ram [2**RAM_LOG2];

  logic                 q_rw   [QDEPTH];
  logic [ADDR_BITS-1:0] q_addr [QDEPTH];
  logic [TAG_BITS-1:0]  q_tag  [QDEPTH];
  logic [QW-1:0]        wr_ptr, rd_ptr;
  logic [QW:0]          count;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, wait_load;
  logic [BW-1:0] beat, beat_n;
  logic          enq, pop, wait_entry, resp_valid, data_ready, wr_fire;

  logic                 head_rw;
  logic [ADDR_BITS-1:0] head_addr, line_addr;
  logic [TAG_BITS-1:0]  head_tag;
  logic [RAM_LOG2-1:0]  rd_idx, wr_idx;
  logic                 unused_addr_bits;

  assign mem.mem_req_ready = !reset && (count < (QW+1)'(QDEPTH));
  assign enq       = mem.mem_req_valid && mem.mem_req_ready;
  assign head_rw   = q_rw[rd_ptr];
  assign head_addr = q_addr[rd_ptr];
  assign head_tag  = q_tag[rd_ptr];
  assign line_addr = {head_addr[ADDR_BITS-1:BW], beat};
  assign rd_idx    = line_addr[RAM_LOG2-1:0];
  assign wr_idx    = head_addr[RAM_LOG2-1:0];
  assign unused_addr_bits = ^{line_addr[ADDR_BITS-1:RAM_LOG2], head_addr[ADDR_BITS-1:RAM_LOG2]};

`ifdef MEM_RANDOM_LATENCY_EN
  logic [15:0] lfsr;
  assign wait_load = CW'(LATENCY - 2) + CW'(lfsr[2:0]);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else if (wait_entry) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign wait_load = CW'(LATENCY - 2);
`endif

  // IDLE also reacts to a same-edge enqueue so an empty block meets LATENCY exactly.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    beat_n     = beat;
    pop        = 1'b0;
    wait_entry = 1'b0;
    resp_valid = 1'b0;
    data_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0 || enq) begin
          state_n    = S_WAIT;
          cnt_n      = wait_load;
          wait_entry = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = head_rw ? S_WDATA : S_RBURST;
          beat_n  = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_RBURST: begin
        resp_valid = 1'b1;
        beat_n     = beat + BW'(1);
        if (beat == BW'(BEATS - 1)) begin
          pop     = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WDATA: begin
        data_ready = 1'b1;
        if (mem.mem_req_data_valid) begin
          pop     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign wr_fire                = data_ready && mem.mem_req_data_valid && !reset;
  assign mem.mem_resp_valid     = resp_valid;
  assign mem.mem_req_data_ready = data_ready;

  always_comb begin
    mem.mem_resp_tag  = '0;
    mem.mem_resp_data = '0;
    if (resp_valid) begin
      mem.mem_resp_tag  = head_tag;
      mem.mem_resp_data = ram[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      beat   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      beat   <= beat_n;
      wr_ptr <= wr_ptr + QW'(enq);
      rd_ptr <= rd_ptr + QW'(pop);
      count  <= count + (QW+1)'(enq) - (QW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rw[wr_ptr]   <= mem.mem_req_rw;
      q_addr[wr_ptr] <= mem.mem_req_addr;
      q_tag[wr_ptr]  <= mem.mem_req_tag;
    end
  end

  // Backing store is deliberately left out of reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < MW; b++) begin
        if (mem.mem_req_data_mask[b]) ram[wr_idx][b*8 +: 8] <= mem.mem_req_data_bits[b*8 +: 8];
      end
    end
  end
endmodule
